// File: rtl/phase_gen.sv
// rtl/phase_gen.sv - Q3.13 radian phase accumulator with wrap at +pi
// Feeds a CORDIC stage over a valid/ready handshake; supports continuous and burst runs.
module phase_gen #(
  parameter int                          PHASE_W = 16,
  parameter logic signed [PHASE_W-1:0]   PI_POS  = 16'sh6488,
  parameter logic signed [PHASE_W-1:0]   PI_NEG  = 16'sh9B78,
  parameter int                          INC_DEF = 256,
  parameter int                          CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic [PHASE_W-1:0]  inc_in,
  input  logic                inc_load,
  input  logic [CNT_W-1:0]    burst_len,
  output logic [PHASE_W-1:0]  phase,
  output logic                phase_tvalid,
  input  logic                phase_tready,
  output logic                busy,
  output logic                done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [PHASE_W-1:0] INC_RST = PHASE_W'(INC_DEF);
  localparam logic [PHASE_W-1:0] INC_MAX = PI_POS - {{(PHASE_W-1){1'b0}}, 1'b1};
  localparam logic [PHASE_W-1:0] MAG_MASK = {1'b0, {(PHASE_W-1){1'b1}}};

  logic [1:0]          state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic                tvalid_q, tvalid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [PHASE_W-1:0]  inc_q, inc_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    len_q, len_d;

  logic                       beat;
  logic                       last_beat;
  logic [PHASE_W-1:0]         inc_mag;
  logic signed [PHASE_W:0]    sum_w;
  logic signed [PHASE_W:0]    pi_pos_ext;
  logic signed [PHASE_W:0]    span_ext;
  logic signed [PHASE_W:0]    folded_w;
  logic [PHASE_W-1:0]         phase_next;

  assign beat      = tvalid_q & phase_tready;
  assign last_beat = (len_q != '0) && (count_q == len_q - 1'b1);

  // Increment is a non-negative magnitude below +pi, so one fold by 2*pi suffices.
  assign pi_pos_ext = {PI_POS[PHASE_W-1], PI_POS};
  assign span_ext   = pi_pos_ext - {PI_NEG[PHASE_W-1], PI_NEG};
  assign sum_w      = $signed({phase_q[PHASE_W-1], phase_q}) + $signed({inc_q[PHASE_W-1], inc_q});
  assign folded_w   = sum_w - span_ext;
  assign phase_next = (sum_w >= pi_pos_ext) ? folded_w[PHASE_W-1:0] : sum_w[PHASE_W-1:0];

  assign inc_mag = inc_in & MAG_MASK;

  always_comb begin
    inc_d = inc_q;
    if (inc_load) begin
      inc_d = (inc_mag > INC_MAX) ? INC_MAX : inc_mag;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    tvalid_d = tvalid_q;
    done_d   = 1'b0;
    count_d  = count_q;
    len_d    = len_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d  = ST_RUN;
          phase_d  = '0;
          tvalid_d = 1'b1;
          count_d  = '0;
          len_d    = burst_len;
        end
      end
      ST_RUN: begin
        if (beat) begin
          phase_d = phase_next;
          count_d = count_q + 1'b1;
          if (last_beat || stop) begin
            state_d  = ST_IDLE;
            tvalid_d = 1'b0;
            done_d   = 1'b1;
          end
        end else if (stop) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Current word stays presented; it is the final beat of the run.
        if (beat) begin
          state_d  = ST_IDLE;
          tvalid_d = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      tvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      inc_q    <= INC_RST;
      count_q  <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      tvalid_q <= tvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      inc_q    <= inc_d;
      count_q  <= count_d;
      len_q    <= len_d;
    end
  end

  assign phase        = phase_q;
  assign phase_tvalid = tvalid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
